// File: rtl/div_seq.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU that borrows the shared ALU for one subtract per quotient bit.
// Optional single-entry result cache is enabled by defining DIV_SEQ_CACHE_EN.
module div_seq #(
  parameter int WIDTH   = 32,
  parameter int ALU_SEL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_data,
  output logic               busy,
  output logic               alu_own,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [ALU_SEL-1:0] alu_sel,
  input  logic [WIDTH-1:0]   alu_out
);

  localparam logic [ALU_SEL-1:0] ALU_ADD = ALU_SEL'(0);
  localparam logic [ALU_SEL-1:0] ALU_SUB = ALU_SEL'(1);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
  logic [WIDTH-1:0] bmag_reg, bmag_next, quot_reg, quot_next;
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;
  logic             resp_valid_reg, resp_valid_next;
  logic [WIDTH-1:0] resp_data_reg, resp_data_next;

  logic             is_signed;
  logic [WIDTH-1:0] a_mag, b_mag, fix_mag;
  logic             fix_neg;
  logic [WIDTH:0]   shifted;
  logic             ge;

`ifdef DIV_SEQ_CACHE_EN
  logic             cache_valid_reg, cache_valid_next;
  logic [WIDTH-1:0] cache_a_reg, cache_a_next, cache_b_reg, cache_b_next;
  logic             cache_signed_reg, cache_signed_next;
  logic [WIDTH-1:0] cache_q_reg, cache_q_next, cache_r_reg, cache_r_next;
  logic             cache_hit;
`endif

  assign req_ready  = (state_reg == IDLE) && !rst;
  assign busy       = (state_reg != IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;

  always_comb begin
    state_next      = state_reg;
    op_next         = op_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    bmag_next       = bmag_reg;
    quot_next       = quot_reg;
    rem_next        = rem_reg;
    count_next      = count_reg;
    neg_q_next      = neg_q_reg;
    neg_r_next      = neg_r_reg;
    resp_valid_next = resp_valid_reg;
    resp_data_next  = resp_data_reg;
    alu_own         = 1'b0;
    alu_a           = '0;
    alu_b           = '0;
    alu_sel         = ALU_ADD;

    is_signed = !op_reg[0];
    a_mag     = (is_signed && a_reg[WIDTH-1]) ? -a_reg : a_reg;
    b_mag     = (is_signed && b_reg[WIDTH-1]) ? -b_reg : b_reg;
    fix_mag   = op_reg[1] ? rem_reg[WIDTH-1:0] : quot_reg;
    fix_neg   = op_reg[1] ? neg_r_reg : neg_q_reg;
    shifted   = {rem_reg[WIDTH-1:0], quot_reg[WIDTH-1]};
    ge        = shifted[WIDTH] | (shifted[WIDTH-1:0] >= bmag_reg);

`ifdef DIV_SEQ_CACHE_EN
    cache_valid_next  = cache_valid_reg;
    cache_a_next      = cache_a_reg;
    cache_b_next      = cache_b_reg;
    cache_signed_next = cache_signed_reg;
    cache_q_next      = cache_q_reg;
    cache_r_next      = cache_r_reg;
    cache_hit = cache_valid_reg && (cache_a_reg == req_a) && (cache_b_reg == req_b)
                && (cache_signed_reg == !req_op[0]);
`endif

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          op_next    = req_op;
          a_next     = req_a;
          b_next     = req_b;
          state_next = PREP;
`ifdef DIV_SEQ_CACHE_EN
          if (cache_hit) begin
            state_next      = DONE;
            resp_valid_next = 1'b1;
            resp_data_next  = req_op[1] ? cache_r_reg : cache_q_reg;
          end
`endif
        end
      end
      PREP: begin
        neg_q_next = is_signed && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
        neg_r_next = is_signed && a_reg[WIDTH-1];
        bmag_next  = b_mag;
        quot_next  = a_mag;
        rem_next   = '0;
        count_next = CW'(WIDTH - 1);
        if (b_reg == '0) begin
          state_next      = DONE;
          resp_valid_next = 1'b1;
          resp_data_next  = op_reg[1] ? a_reg : '1;
        end else if (is_signed && a_reg == MIN_INT && b_reg == '1) begin
          state_next      = DONE;
          resp_valid_next = 1'b1;
          resp_data_next  = op_reg[1] ? '0 : MIN_INT;
        end else begin
          state_next = ITER;
        end
      end
      ITER: begin
        alu_own    = 1'b1;
        alu_a      = shifted[WIDTH-1:0];
        alu_b      = bmag_reg;
        alu_sel    = ALU_SUB;
        rem_next   = ge ? {1'b0, alu_out} : shifted;
        quot_next  = {quot_reg[WIDTH-2:0], ge};
        count_next = count_reg - 1'b1;
        if (count_reg == '0) state_next = FIX;
      end
      FIX: begin
        alu_own         = 1'b1;
        alu_b           = fix_mag;
        alu_sel         = ALU_SUB;
        resp_data_next  = (is_signed && fix_neg) ? alu_out : fix_mag;
        resp_valid_next = 1'b1;
        state_next      = DONE;
`ifdef DIV_SEQ_CACHE_EN
        // Both results are stored so a later request for the other one also hits.
        cache_valid_next  = 1'b1;
        cache_a_next      = a_reg;
        cache_b_next      = b_reg;
        cache_signed_next = is_signed;
        cache_q_next      = (is_signed && neg_q_reg) ? -quot_reg : quot_reg;
        cache_r_next      = (is_signed && neg_r_reg) ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
`endif
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= resp_valid_next;
      resp_data_reg  <= resp_data_next;
    end
    op_reg    <= op_next;
    a_reg     <= a_next;
    b_reg     <= b_next;
    bmag_reg  <= bmag_next;
    quot_reg  <= quot_next;
    rem_reg   <= rem_next;
    count_reg <= count_next;
    neg_q_reg <= neg_q_next;
    neg_r_reg <= neg_r_next;
  end

`ifdef DIV_SEQ_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst) cache_valid_reg <= 1'b0;
    else     cache_valid_reg <= cache_valid_next;
    cache_a_reg      <= cache_a_next;
    cache_b_reg      <= cache_b_next;
    cache_signed_reg <= cache_signed_next;
    cache_q_reg      <= cache_q_next;
    cache_r_reg      <= cache_r_next;
  end
`endif

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed RV32M cases, specials, back-pressure, mid-run reset and random operands.
// The bench models the shared ALU and predicts results with plain integer arithmetic.
module tb_div_seq;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
`ifdef DIV_SEQ_CACHE_EN
  localparam int LAT_HIT = 1;
  localparam int OWN_HIT = 0;
`else
  localparam int LAT_HIT = 35;
  localparam int OWN_HIT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0, req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        busy, alu_own;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign alu_out = (alu_sel == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

  div_seq #(.WIDTH(32), .ALU_SEL(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .alu_own(alu_own),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
  );

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (op[0]) return op[1] ? (a % b) : (a / b);
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Runs one request; lat is the cycle index (accept cycle = 0) where resp_valid is first seen.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold,
                        output logic [31:0] data, output int lat, output int own_cycles, output int alu_err);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1; own_cycles = 0; alu_err = 0;
    while (lat <= 100) begin
      @(negedge clk);
      if (resp_valid) break;
      if (alu_own) begin
        own_cycles++;
        if (alu_sel !== ALU_SUB) alu_err++;
      end else if (alu_sel !== ALU_ADD || alu_a !== 32'h0 || alu_b !== 32'h0) begin
        alu_err++;
      end
      @(posedge clk);
      lat++;
    end
    if (alu_own !== 1'b0 || alu_sel !== ALU_ADD) alu_err++;
    data = resp_data;
    if (!hold) begin
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd10; req_b = 32'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
    total++; if (alu_own !== 1'b0) begin bad++; $display("FAIL reset_alu_own got=%b want=0", alu_own); end
    total++; if (alu_sel !== ALU_ADD || alu_a !== 0 || alu_b !== 0) begin
      bad++; $display("FAIL reset_alu_bus got sel=%h a=%h b=%h want sel=%h a=0 b=0", alu_sel, alu_a, alu_b, ALU_ADD);
    end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready_idle got=%b want=1", req_ready); end
    $display("reset: busy=%b resp_valid=%b req_ready=%b", busy, resp_valid, req_ready);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, want;
    int          lat, own;
  } vec_t;

  task automatic test_directed;
    vec_t v[12];
    logic [31:0] d;
    int lat, own, err;
    v[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         35,      33};
    v[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          LAT_HIT, OWN_HIT};
    v[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35,      33};
    v[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  LAT_HIT, OWN_HIT};
    v[4]  = '{2'b01, 32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          35,      33};
    v[5]  = '{2'b11, 32'hFFFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  LAT_HIT, OWN_HIT};
    v[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  2,       0};
    v[7]  = '{2'b10, 32'd5,          32'd0,          32'd5,          2,       0};
    v[8]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2,       0};
    v[9]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          2,       0};
    v[10] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  35,      33};
    v[11] = '{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  35,      33};
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, 1'b0, d, lat, own, err);
      $display("directed op=%0d a=%h b=%h data=%h lat=%0d own=%0d", v[i].op, v[i].a, v[i].b, d, lat, own);
      total++; if (d !== v[i].want) begin bad++; $display("FAIL dir%0d_data got=%h want=%h", i, d, v[i].want); end
      total++; if (lat != v[i].lat) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
      total++; if (own != v[i].own) begin bad++; $display("FAIL dir%0d_alu_own_cycles got=%0d want=%0d", i, own, v[i].own); end
      total++; if (err != 0) begin bad++; $display("FAIL dir%0d_alu_bus got=%0d bad cycles want=0", i, err); end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d, want;
    int lat, own, err;
    want = ref_result(2'b00, 32'd1000, 32'hFFFF_FFFD);
    run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 1'b1, d, lat, own, err);
    total++; if (d !== want) begin bad++; $display("FAIL hold_data got=%h want=%h", d, want); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      total++; if (resp_valid !== 1'b1 || resp_data !== want || req_ready !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL hold_cycle%0d got valid=%b data=%h ready=%b busy=%b want 1 %h 0 1",
                        c, resp_valid, resp_data, req_ready, busy, want);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release got busy=%b valid=%b ready=%b want 0 0 1", busy, resp_valid, req_ready);
    end
    $display("backpressure: data=%h released", d);
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int lat, own, err;
    run_op(2'b01, 32'd9, 32'd3, 1'b0, d, lat, own, err);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL mid_prime_data got=%h want=3", d); end
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd100; req_b = 32'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (22) @(posedge clk);
    @(negedge clk);
    total++; if (alu_own !== 1'b1 || alu_sel !== ALU_SUB) begin
      bad++; $display("FAIL mid_iter_alu got own=%b sel=%h want own=1 sel=%h", alu_own, alu_sel, ALU_SUB);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || resp_valid !== 1'b0 || alu_own !== 1'b0 || alu_sel !== ALU_ADD) begin
      bad++; $display("FAIL mid_reset_state got busy=%b valid=%b own=%b sel=%h want 0 0 0 %h",
                      busy, resp_valid, alu_own, alu_sel, ALU_ADD);
    end
    run_op(2'b01, 32'd9, 32'd3, 1'b0, d, lat, own, err);
    $display("reset_mid: DIVU 9/3 data=%h lat=%0d", d, lat);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL mid_after_data got=%h want=3", d); end
    total++; if (lat != 35) begin bad++; $display("FAIL mid_after_latency got=%0d want=35", lat); end
  endtask

  task automatic test_random;
    logic [31:0] a, b, d, want;
    logic [1:0] op;
    int lat, own, err, exp_lat;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(1, 20);
        1: b = 32'h0;
        2: b = -32'($urandom_range(1, 20));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      if (n % 7 == 0) a = -32'($urandom_range(0, 1000));
      want = ref_result(op, a, b);
      exp_lat = is_special(op, a, b) ? 2 : 35;
      run_op(op, a, b, 1'b0, d, lat, own, err);
      $display("random%0d op=%0d a=%h b=%h data=%h lat=%0d", n, op, a, b, d, lat);
      total++; if (d !== want) begin bad++; $display("FAIL rnd%0d_data got=%h want=%h", n, d, want); end
      total++; if (lat != exp_lat) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, exp_lat); end
      total++; if (err != 0) begin bad++; $display("FAIL rnd%0d_alu_bus got=%0d bad cycles want=0", n, err); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
